proc_sequencer: RTL and testbench

- Synthesizable run controller for the 5-stage MIPS pipeline; takes over the program-load, run and dump sequencing currently scripted in the simulation top.
- Streams a program into instruction memory and releases the PC, then runs the pipeline until a syscall retires or a cycle budget expires.
- After the run it freezes the datapath and streams out register-file and data-memory contents over a valid/ready port.

---
 rtl/proc_sequencer_if.sv | 56 +++++
 rtl/proc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_proc_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_sequencer_if.sv
// Signal bundle between the run sequencer and the pipeline / loader / dump consumer.
// The sequencer takes the slave view; whatever drives start/ld/dump takes master.
interface proc_sequencer_if;
  // session control and status
  logic        start;
  logic [8:0]  progLen;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        lenErr;
  logic [15:0] cycleNo;

  // program load stream and instruction-memory side
  logic        ldValid;
  logic [31:0] ldData;
  logic        ldReady;
  logic        imemWrite;
  logic        imemRead;
  logic [31:0] imemAddr;
  logic [31:0] imemData;

  // pipeline control
  logic        initializing;
  logic        ending;
  logic        pcReset;
  logic        pcWrite;
  logic        runEn;
  logic        syscall_W;

  // dump addressing and output stream
  logic [4:0]  dumpReg;
  logic [31:0] regData;
  logic [31:0] dumpMemAddr;
  logic [7:0]  memByte;
  logic        dumpValid;
  logic        dumpReady;
  logic        dumpIsMem;
  logic [7:0]  dumpIdx;
  logic [31:0] dumpData;

  modport slave (
    input  start, progLen, ldValid, ldData, syscall_W, regData, memByte, dumpReady,
    output busy, done, timeout, lenErr, cycleNo,
    output ldReady, imemWrite, imemRead, imemAddr, imemData,
    output initializing, ending, pcReset, pcWrite, runEn,
    output dumpReg, dumpMemAddr, dumpValid, dumpIsMem, dumpIdx, dumpData
  );

  modport master (
    output start, progLen, ldValid, ldData, syscall_W, regData, memByte, dumpReady,
    input  busy, done, timeout, lenErr, cycleNo,
    input  ldReady, imemWrite, imemRead, imemAddr, imemData,
    input  initializing, ending, pcReset, pcWrite, runEn,
    input  dumpReg, dumpMemAddr, dumpValid, dumpIsMem, dumpIdx, dumpData
  );
endinterface

// File: rtl/proc_sequencer.sv
// Run controller for the 5-stage MIPS pipeline: loads a program into imem,
// runs until syscall or cycle budget, then streams out registers and data memory.
module proc_sequencer #(
  parameter int          PROG_MAX       = 256,
  parameter int          NUM_REGS       = 32,
  parameter int          MEM_DUMP_BYTES = 64,
  parameter logic [15:0] MAX_CYCLES     = 16'hFFFF
) (
  input logic             clk,
  input logic             resetN,
  proc_sequencer_if.slave sif
);

  localparam int             NUM_ITEMS = NUM_REGS + MEM_DUMP_BYTES;
  localparam int             IW        = $clog2(NUM_ITEMS);
  localparam logic [IW-1:0]  REG_CNT   = IW'(NUM_REGS);
  localparam logic [IW-1:0]  LAST_ITEM = IW'(NUM_ITEMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_ADDR,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [8:0]    prog_len;
  logic [8:0]    word_idx;
  logic [IW-1:0] item;
  logic [IW-1:0] mem_off;
  logic [15:0]   cycle_no;
  logic [31:0]   dump_data;
  logic          timeout_q;
  logic          len_err;

  logic idle_like;
  logic start_ok;
  logic len_bad;
  logic ld_hs;
  logic ld_last;
  logic dump_hs;
  logic is_mem;
  logic last_item;
  logic budget_hit;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign start_ok   = sif.start && idle_like;
  assign len_bad    = (sif.progLen == 9'd0) || ({23'b0, sif.progLen} > PROG_MAX);
  assign ld_hs      = (state == S_LOAD) && sif.ldValid;
  assign ld_last    = (word_idx == prog_len - 9'd1);
  assign dump_hs    = (state == S_DUMP_OUT) && sif.dumpReady;
  assign is_mem     = (item >= REG_CNT);
  assign mem_off    = item - REG_CNT;
  assign last_item  = (item == LAST_ITEM);
  assign budget_hit = (cycle_no == MAX_CYCLES - 16'd1);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok && !len_bad) state_nx = S_LOAD;
      S_LOAD:         if (ld_hs && ld_last)     state_nx = S_RUN;
      // syscall and budget expiry both leave RUN; timeout flag is resolved below
      S_RUN:          if (sif.syscall_W || budget_hit) state_nx = S_DUMP_ADDR;
      S_DUMP_ADDR:    state_nx = S_DUMP_OUT;
      S_DUMP_OUT:     if (dump_hs) state_nx = last_item ? S_DONE : S_DUMP_ADDR;
      default:        state_nx = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- control outputs
  logic ctl_init, ctl_ending, ctl_pc_reset, ctl_pc_write;
  logic ctl_imem_read, ctl_imem_write, ctl_run_en, ctl_ld_ready;
  logic ctl_dump_valid, ctl_busy, ctl_done;

  always_comb begin
    ctl_init       = 1'b0;
    ctl_ending     = 1'b0;
    ctl_pc_reset   = 1'b0;
    ctl_pc_write   = 1'b0;
    ctl_imem_read  = 1'b0;
    ctl_imem_write = 1'b0;
    ctl_run_en     = 1'b0;
    ctl_ld_ready   = 1'b0;
    ctl_dump_valid = 1'b0;
    ctl_busy       = 1'b0;
    ctl_done       = 1'b0;
    case (state)
      S_IDLE: begin
        ctl_init     = 1'b1;
        ctl_pc_reset = 1'b1;
      end
      S_LOAD: begin
        ctl_init       = 1'b1;
        ctl_pc_reset   = 1'b1;
        ctl_ld_ready   = 1'b1;
        ctl_imem_write = sif.ldValid;
        ctl_busy       = 1'b1;
      end
      S_RUN: begin
        ctl_pc_write  = 1'b1;
        ctl_imem_read = 1'b1;
        // squash commits behind the retiring syscall in the same cycle
        ctl_run_en    = !sif.syscall_W;
        ctl_busy      = 1'b1;
      end
      S_DUMP_ADDR: begin
        ctl_ending = 1'b1;
        ctl_busy   = 1'b1;
      end
      S_DUMP_OUT: begin
        ctl_ending     = 1'b1;
        ctl_dump_valid = 1'b1;
        ctl_busy       = 1'b1;
      end
      S_DONE: begin
        ctl_ending = 1'b1;
        ctl_done   = 1'b1;
      end
      default: begin
        ctl_init     = 1'b1;
        ctl_pc_reset = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prog_len  <= '0;
      word_idx  <= '0;
      item      <= '0;
      cycle_no  <= '0;
      dump_data <= '0;
      timeout_q <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      if (start_ok) begin
        if (len_bad) begin
          len_err <= 1'b1;
        end else begin
          len_err   <= 1'b0;
          timeout_q <= 1'b0;
          cycle_no  <= '0;
          prog_len  <= sif.progLen;
          word_idx  <= '0;
          item      <= '0;
        end
      end

      if (ld_hs) word_idx <= word_idx + 9'd1;

      if (state == S_RUN) begin
        if (cycle_no != 16'hFFFF) cycle_no <= cycle_no + 16'd1;
        if (!sif.syscall_W && budget_hit) timeout_q <= 1'b1;
      end

      // addresses have settled for a full cycle by the end of DUMP_ADDR
      if (state == S_DUMP_ADDR)
        dump_data <= is_mem ? {24'b0, sif.memByte} : sif.regData;

      if (dump_hs && !last_item) item <= item + IW'(1);
    end
  end

  // ---------------------------------------------------------- port drive
  assign sif.initializing = ctl_init;
  assign sif.ending       = ctl_ending;
  assign sif.pcReset      = ctl_pc_reset;
  assign sif.pcWrite      = ctl_pc_write;
  assign sif.imemRead     = ctl_imem_read;
  assign sif.imemWrite    = ctl_imem_write;
  assign sif.runEn        = ctl_run_en;
  assign sif.ldReady      = ctl_ld_ready;
  assign sif.dumpValid    = ctl_dump_valid;
  assign sif.busy         = ctl_busy;
  assign sif.done         = ctl_done;

  assign sif.imemAddr     = {21'b0, word_idx, 2'b00};
  assign sif.imemData     = sif.ldData;

  assign sif.dumpReg      = is_mem ? 5'd0 : 5'(item);
  assign sif.dumpMemAddr  = is_mem ? 32'(mem_off) : 32'd0;
  assign sif.dumpIsMem    = is_mem;
  assign sif.dumpIdx      = is_mem ? 8'(mem_off) : 8'(item);
  assign sif.dumpData     = dump_data;

  assign sif.cycleNo      = cycle_no;
  assign sif.timeout      = timeout_q;
  assign sif.lenErr       = len_err;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: stub register file / data memory feed the
// dump port, a write monitor logs imem stores, checks are immediate assertions.
module tb_proc_sequencer;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  proc_sequencer_if sif();

  proc_sequencer #(
    .PROG_MAX(256), .NUM_REGS(32), .MEM_DUMP_BYTES(64), .MAX_CYCLES(16'd20)
  ) dut (
    .clk(clk), .resetN(resetN), .sif(sif)
  );

  // datapath stand-ins read through the dump address muxes
  logic [31:0] rf  [0:31];
  logic [7:0]  mem [0:63];
  assign sif.regData = rf[sif.dumpReg];
  assign sif.memByte = mem[sif.dumpMemAddr[5:0]];

  int          wr_total = 0;
  logic [31:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  always @(posedge clk) begin
    if (resetN === 1'b1 && sif.imemWrite === 1'b1) begin
      wr_addr[wr_total[7:0]] <= sif.imemAddr;
      wr_data[wr_total[7:0]] <= sif.imemData;
      wr_total <= wr_total + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [8:0] len);
    sif.start   = 1'b1;
    sif.progLen = len;
    tick();
    sif.start   = 1'b0;
    #1;
  endtask

  logic [31:0] prog [0:7];
  logic [31:0] d_data [0:127];
  logic [7:0]  d_idx  [0:127];
  logic        d_mem  [0:127];

  initial begin
    int base, n_items, cyc, bad;

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[17] = 32'd5; rf[16] = 32'd2; rf[18] = 32'hFFFF_FFFD; rf[9] = 32'd3;
    for (int i = 0; i < 64; i++) mem[i] = 8'hA0 + 8'(i);
    prog[0] = 32'h2011_0005; prog[1] = 32'h2010_0002; prog[2] = 32'hAC11_0000;
    prog[3] = 32'h0230_4820; prog[4] = 32'h0011_4842; prog[5] = 32'h0211_9022;
    prog[6] = 32'h2002_000A; prog[7] = 32'h0000_000C;

    sif.start = 0; sif.progLen = 0; sif.ldValid = 0; sif.ldData = 0;
    sif.syscall_W = 0; sif.dumpReady = 0;

    // reset state
    resetN = 1'b0;
    #3;
    check("rst_init",    sif.initializing, 1);
    check("rst_pcreset", sif.pcReset, 1);
    check("rst_ending",  sif.ending, 0);
    check("rst_busy",    sif.busy, 0);
    check("rst_ldready", sif.ldReady, 0);
    check("rst_pcwrite", sif.pcWrite, 0);
    check("rst_dvalid",  sif.dumpValid, 0);
    check("rst_cycle",   sif.cycleNo, 0);
    check("rst_ddata",   sif.dumpData, 0);
    check("rst_flags",   {sif.done, sif.timeout, sif.lenErr, sif.runEn, sif.imemWrite, sif.imemRead}, 0);
    tick();
    resetN = 1'b1;
    tick();

    // length errors keep IDLE
    pulse_start(9'd0);
    check("len0_err",   sif.lenErr, 1);
    check("len0_busy",  sif.busy, 0);
    check("len0_ready", sif.ldReady, 0);
    pulse_start(9'd257);
    check("len257_err",   sif.lenErr, 1);
    check("len257_ready", sif.ldReady, 0);
    check("len257_init",  sif.initializing, 1);

    // load 8 words with ldValid held high
    pulse_start(9'd8);
    check("ld_lenerr_clr", sif.lenErr, 0);
    base = wr_total;
    sif.ldValid = 1'b1;
    sif.ldData  = prog[0];
    #1;
    check("ld_ready", sif.ldReady, 1);
    check("ld_wr0",   sif.imemWrite, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 7) sif.ldData = prog[k+1];
    end
    sif.ldValid = 1'b0;
    #1;
    check("ld_count", wr_total - base, 8);
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (wr_addr[base+k] !== 32'(4*k) || wr_data[base+k] !== prog[k]) bad++;
    check("ld_addr_data", bad, 0);
    check("ld_last_addr", wr_addr[base+7], 32'h1C);
    check("run_pcwrite",  sif.pcWrite, 1);
    check("run_init",     {sif.initializing, sif.pcReset, sif.ending, sif.ldReady}, 0);
    check("run_en",       {sif.runEn, sif.imemRead, sif.busy}, 3'b111);
    check("run_cycle0",   sif.cycleNo, 0);

    repeat (4) tick();
    check("run_cycle4", sif.cycleNo, 4);
    sif.syscall_W = 1'b1;
    #1;
    check("sys_runen", sif.runEn, 0);
    tick();
    sif.syscall_W = 1'b0;
    #1;
    check("sys_dump_ctl", {sif.ending, sif.pcWrite, sif.runEn, sif.imemRead}, 4'b1000);
    check("sys_cycle",    sif.cycleNo, 5);
    check("sys_timeout",  sif.timeout, 0);

    // free-running dump
    sif.dumpReady = 1'b1;
    n_items = 0; cyc = 0;
    while (sif.done !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
      if (sif.dumpValid === 1'b1 && n_items < 128) begin
        d_data[n_items] = sif.dumpData;
        d_idx[n_items]  = sif.dumpIdx;
        d_mem[n_items]  = sif.dumpIsMem;
        n_items++;
      end
    end
    check("dump_items",  n_items, 96);
    check("dump_cycles", cyc, 192);
    check("dump_r17", d_data[17], 32'd5);
    check("dump_r16", d_data[16], 32'd2);
    check("dump_r18", d_data[18], 32'hFFFF_FFFD);
    check("dump_r9",  d_data[9],  32'd3);
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      if (i < 32) begin
        if (d_idx[i] !== 8'(i) || d_mem[i] !== 1'b0) bad++;
      end else begin
        if (d_idx[i] !== 8'(i-32) || d_mem[i] !== 1'b1 ||
            d_data[i] !== {24'b0, 8'hA0 + 8'(i-32)}) bad++;
      end
    end
    check("dump_order", bad, 0);
    check("done_flags", {sif.done, sif.busy, sif.ending, sif.pcReset, sif.pcWrite}, 5'b10100);

    // load backpressure: ldValid every other cycle
    pulse_start(9'd3);
    check("bp_done_clr", sif.done, 0);
    check("bp_cycle_clr", sif.cycleNo, 0);
    base = wr_total;
    for (int c = 0; c < 6; c++) begin
      sif.ldValid = (c % 2 == 1);
      sif.ldData  = 32'hC0DE_0000 + 32'(c);
      #1;
      check("bp_wr_follows_valid", sif.imemWrite, sif.ldValid);
      check("bp_ready", sif.ldReady, 1);
      tick();
    end
    sif.ldValid = 1'b0;
    #1;
    check("bp_count", wr_total - base, 3);
    check("bp_addr", {wr_addr[base][7:0], wr_addr[base+1][7:0], wr_addr[base+2][7:0]}, 24'h000408);
    check("bp_data1", wr_data[base+1], 32'hC0DE_0003);
    check("bp_in_run", sif.pcWrite, 1);

    // timeout run with a stray start mid-run
    repeat (3) tick();
    sif.start = 1'b1; sif.progLen = 9'd0;
    tick();
    sif.start = 1'b0;
    #1;
    check("run_start_ignored", sif.lenErr, 0);
    repeat (15) tick();
    check("to_cycle19", sif.cycleNo, 19);
    check("to_pcwrite20", sif.pcWrite, 1);
    tick();
    check("to_flag",    sif.timeout, 1);
    check("to_cycle20", sif.cycleNo, 20);
    check("to_pcwrite21", sif.pcWrite, 0);

    // dump backpressure on register 3
    sif.dumpReady = 1'b1;
    repeat (6) tick();
    sif.dumpReady = 1'b0;
    tick();
    for (int h = 0; h < 5; h++) begin
      check("hold_valid", sif.dumpValid, 1);
      check("hold_idx",   sif.dumpIdx, 3);
      check("hold_data",  sif.dumpData, rf[3]);
      tick();
    end
    check("hold_still", {sif.dumpValid, sif.dumpIdx}, 9'h103);
    sif.dumpReady = 1'b1;
    tick();
    check("hs_adv_valid", sif.dumpValid, 0);
    check("hs_adv_reg",   sif.dumpReg, 4);
    cyc = 0;
    while (sif.done !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("to_done",    sif.done, 1);
    check("to_keep",    sif.timeout, 1);
    check("to_cycle_hold", sif.cycleNo, 20);

    // reset in the middle of a load
    pulse_start(9'd5);
    base = wr_total;
    sif.ldValid = 1'b1; sif.ldData = 32'h1111_0000;
    tick();
    sif.ldData = 32'h1111_0001;
    tick();
    resetN = 1'b0;
    #1;
    check("mr_written",  wr_total - base, 2);
    check("mr_ctl",      {sif.ldReady, sif.imemWrite, sif.busy, sif.done, sif.timeout}, 0);
    check("mr_init",     {sif.initializing, sif.pcReset, sif.ending}, 3'b110);
    check("mr_cycle",    sif.cycleNo, 0);
    sif.ldValid = 1'b0;
    #2;
    resetN = 1'b1;
    tick();
    pulse_start(9'd5);
    base = wr_total;
    sif.ldValid = 1'b1; sif.ldData = 32'h2222_0000;
    #1;
    check("rl_addr0", sif.imemAddr, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      sif.ldData = 32'h2222_0001 + 32'(k);
    end
    sif.ldValid = 1'b0;
    #1;
    check("rl_count", wr_total - base, 5);
    check("rl_first", wr_addr[base], 0);
    check("rl_last",  wr_addr[base+4], 32'h10);
    check("rl_run",   sif.pcWrite, 1);
    sif.syscall_W = 1'b1;
    tick();
    sif.syscall_W = 1'b0;
    #1;
    check("rl_dump", sif.ending, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
